// File: rtl/debug_frame_streamer.sv
// Snapshot-and-send engine: latches NUM_CHANNELS debug words on request and
// streams them to the UART tx as bytes (optional header, masked channels,
// selectable byte order, optional XOR checksum) under a tx_start/tx_done handshake.
module debug_frame_streamer #(
  parameter int unsigned NUM_CHANNELS  = 4,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned SEND_HEADER   = 1,
  parameter logic [7:0]  HEADER_BYTE   = 8'hA5,
  parameter int unsigned SEND_CHECKSUM = 1,
  parameter int unsigned BIG_ENDIAN    = 1
) (
  input  logic                               i_clock,
  input  logic                               i_reset,
  input  logic                               i_capture,
  input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] i_data,
  input  logic [NUM_CHANNELS-1:0]            i_channel_mask,
  input  logic                               i_tx_done,
  output logic                               o_tx_start,
  output logic [7:0]                         o_data_tx,
  output logic                               o_busy,
  output logic                               o_done,
  output logic                               o_overrun
);

  localparam int unsigned BYTES_PER_CH = DATA_WIDTH / 8;
  localparam int unsigned NUM_DATA     = NUM_CHANNELS * BYTES_PER_CH;
  localparam int unsigned CK_IDX       = NUM_DATA + 1;
  localparam int unsigned TOT_W        = NUM_CHANNELS * DATA_WIDTH;
  // Frame positions: 0 = header, 1..NUM_DATA = data bytes, CK_IDX = checksum.
  // The pointer may step one past CK_IDX after the checksum byte is sent.
  localparam int unsigned POS_W        = $clog2(NUM_DATA + 3);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_LOAD      = 2'd1,
    S_WAIT_DONE = 2'd2,
    S_DONE      = 2'd3
  } state_t;

  state_t                  r_state;
  logic [TOT_W-1:0]        r_snap;
  logic [NUM_CHANNELS-1:0] r_mask;
  logic [POS_W-1:0]        r_pos;
  logic [7:0]              r_ck;
  logic                    r_pend;
  logic                    r_tx_start;
  logic [7:0]              r_data_tx;
  logic                    r_busy;
  logic                    r_done;
  logic                    r_overrun;

  state_t                  w_state_n;
  logic [TOT_W-1:0]        w_snap_n;
  logic [NUM_CHANNELS-1:0] w_mask_n;
  logic [POS_W-1:0]        w_pos_n;
  logic [7:0]              w_ck_n;
  logic                    w_pend_n;
  logic                    w_tx_start_n;
  logic [7:0]              w_data_tx_n;
  logic                    w_busy_n;
  logic                    w_done_n;
  logic                    w_overrun_n;

  logic [TOT_W-1:0]        w_src_data;
  logic [NUM_CHANNELS-1:0] w_src_mask;
  logic [7:0]              w_src_ck;
  logic [POS_W-1:0]        w_start;
  logic                    w_found;
  logic [POS_W-1:0]        w_found_pos;
  logic [7:0]              w_found_byte;

  // In IDLE the first byte is looked up straight from the inputs so its
  // tx_start can be registered on the capture edge; afterwards from the snapshot.
  assign w_src_data = (r_state == S_IDLE) ? i_data         : r_snap;
  assign w_src_mask = (r_state == S_IDLE) ? i_channel_mask : r_mask;
  assign w_src_ck   = (r_state == S_IDLE) ? 8'h00          : r_ck;
  assign w_start    = (r_state == S_IDLE) ? '0             : r_pos;

  // Find the first active frame position at or after w_start and its byte value.
  always_comb begin
    w_found      = 1'b0;
    w_found_pos  = '0;
    w_found_byte = 8'h00;
    if ((SEND_HEADER != 0) && (w_start == '0)) begin
      w_found      = 1'b1;
      w_found_pos  = '0;
      w_found_byte = HEADER_BYTE;
    end
    for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
      for (int b = 0; b < BYTES_PER_CH; b++) begin
        if (!w_found && w_src_mask[ch] &&
            (POS_W'(1 + ch * BYTES_PER_CH + b) >= w_start)) begin
          w_found      = 1'b1;
          w_found_pos  = POS_W'(1 + ch * BYTES_PER_CH + b);
          w_found_byte = w_src_data[ch * DATA_WIDTH +
                           ((BIG_ENDIAN != 0) ? (BYTES_PER_CH - 1 - b) : b) * 8 +: 8];
        end
      end
    end
    if (!w_found && (SEND_CHECKSUM != 0) && (w_start <= POS_W'(CK_IDX))) begin
      w_found      = 1'b1;
      w_found_pos  = POS_W'(CK_IDX);
      w_found_byte = w_src_ck;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    w_state_n    = r_state;
    w_snap_n     = r_snap;
    w_mask_n     = r_mask;
    w_pos_n      = r_pos;
    w_ck_n       = r_ck;
    w_pend_n     = r_pend;
    w_tx_start_n = 1'b0;
    w_data_tx_n  = r_data_tx;
    w_busy_n     = r_busy;
    w_done_n     = 1'b0;
    w_overrun_n  = r_overrun | (i_capture & (r_state != S_IDLE));

    unique case (r_state)
      S_IDLE: begin
        w_busy_n = 1'b0;
        if (i_capture) begin
          w_snap_n  = i_data;
          w_mask_n  = i_channel_mask;
          w_ck_n    = 8'h00;
          w_busy_n  = 1'b1;
          w_state_n = S_LOAD;
          w_pend_n  = w_found;
          if (w_found) begin
            w_tx_start_n = 1'b1;
            w_data_tx_n  = w_found_byte;
            w_pos_n      = w_found_pos;
          end
        end
      end
      S_LOAD: begin
        if (r_pend) begin
          // First byte was already launched on the capture edge.
          w_pend_n  = 1'b0;
          w_state_n = S_WAIT_DONE;
        end else if (w_found) begin
          w_tx_start_n = 1'b1;
          w_data_tx_n  = w_found_byte;
          w_pos_n      = w_found_pos;
          w_state_n    = S_WAIT_DONE;
        end else begin
          w_done_n  = 1'b1;
          w_busy_n  = 1'b0;
          w_state_n = S_DONE;
        end
      end
      S_WAIT_DONE: begin
        if (i_tx_done) begin
          if ((r_pos != '0) && (r_pos <= POS_W'(NUM_DATA))) begin
            w_ck_n = r_ck ^ r_data_tx;
          end
          w_pos_n   = r_pos + POS_W'(1);
          w_state_n = S_LOAD;
        end
      end
      S_DONE: begin
        w_busy_n  = 1'b0;
        w_state_n = S_IDLE;
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state    <= S_IDLE;
      r_snap     <= '0;
      r_mask     <= '0;
      r_pos      <= '0;
      r_ck       <= 8'h00;
      r_pend     <= 1'b0;
      r_tx_start <= 1'b0;
      r_data_tx  <= 8'h00;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      r_state    <= w_state_n;
      r_snap     <= w_snap_n;
      r_mask     <= w_mask_n;
      r_pos      <= w_pos_n;
      r_ck       <= w_ck_n;
      r_pend     <= w_pend_n;
      r_tx_start <= w_tx_start_n;
      r_data_tx  <= w_data_tx_n;
      r_busy     <= w_busy_n;
      r_done     <= w_done_n;
      r_overrun  <= w_overrun_n;
    end
  end

  assign o_tx_start = r_tx_start;
  assign o_data_tx  = r_data_tx;
  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_overrun  = r_overrun;

endmodule

// File: tb/tb_debug_frame_streamer.sv
// Directed bench for debug_frame_streamer: three parameterisations share
// clock, reset and data; frames are driven from a vector table plus a few
// hand-written sequences (mid-frame capture, spurious tx_done, reset mid-frame).
module tb_debug_frame_streamer;

  localparam logic [127:0] D = {32'hCAFEBABE, 32'h00000000, 32'hDEADBEEF, 32'h11223344};

  logic         clk;
  logic         rst;
  logic [127:0] data;
  logic [3:0]   mask;
  logic         cap  [3];
  logic         txd  [3];
  logic         ts   [3];
  logic [7:0]   dtx  [3];
  logic         busy [3];
  logic         done [3];
  logic         ovr  [3];

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          sel;
    logic [3:0]  mask;
    int          n;
    logic [79:0] bytes;
  } vec_t;

  vec_t vecs [5];

  // Defaults.
  debug_frame_streamer u_def (
    .i_clock(clk), .i_reset(rst), .i_capture(cap[0]), .i_data(data),
    .i_channel_mask(mask), .i_tx_done(txd[0]), .o_tx_start(ts[0]),
    .o_data_tx(dtx[0]), .o_busy(busy[0]), .o_done(done[0]), .o_overrun(ovr[0]));

  // Little-endian, no header.
  debug_frame_streamer #(.SEND_HEADER(0), .BIG_ENDIAN(0)) u_le (
    .i_clock(clk), .i_reset(rst), .i_capture(cap[1]), .i_data(data),
    .i_channel_mask(mask), .i_tx_done(txd[1]), .o_tx_start(ts[1]),
    .o_data_tx(dtx[1]), .o_busy(busy[1]), .o_done(done[1]), .o_overrun(ovr[1]));

  // No header, no checksum.
  debug_frame_streamer #(.SEND_HEADER(0), .SEND_CHECKSUM(0)) u_nh (
    .i_clock(clk), .i_reset(rst), .i_capture(cap[2]), .i_data(data),
    .i_channel_mask(mask), .i_tx_done(txd[2]), .o_tx_start(ts[2]),
    .o_data_tx(dtx[2]), .o_busy(busy[2]), .o_done(done[2]), .o_overrun(ovr[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Capture one frame on DUT s and check every byte, its timing and the done pulse.
  // tx_done is returned 10 cycles after each start; with mid=1 a capture and a
  // zeroed i_data accompany the 3rd byte's tx_done.
  task automatic run_frame(input int s, input logic [3:0] m, input int n,
                           input logic [79:0] ev, input bit mid);
    logic [7:0] hold;
    bit         stable;
    @(negedge clk);
    data   = D;
    mask   = m;
    cap[s] = 1'b1;
    @(negedge clk);
    cap[s] = 1'b0;
    mask   = ~m;
    chk("busy_after_capture", 32'(busy[s]), 32'd1);
    if (n == 0) begin
      chk("empty_no_start", 32'(ts[s]), 32'd0);
      @(negedge clk);
      chk("empty_done", 32'(done[s]), 32'd1);
      chk("empty_start_still_low", 32'(ts[s]), 32'd0);
      @(negedge clk);
      chk("empty_done_single", 32'(done[s]), 32'd0);
      return;
    end
    for (int k = 0; k < n; k++) begin
      chk("tx_start", 32'(ts[s]), 32'd1);
      chk("byte", 32'(dtx[s]), 32'(ev[79 - 8*k -: 8]));
      hold   = dtx[s];
      stable = 1'b1;
      for (int j = 1; j <= 10; j++) begin
        @(negedge clk);
        if (ts[s] !== 1'b0 || dtx[s] !== hold || done[s] !== 1'b0) stable = 1'b0;
        if (j == 10) begin
          txd[s] = 1'b1;
          if (mid && k == 2) begin
            cap[s] = 1'b1;
            data   = '0;
          end
        end
      end
      chk("wait_done_hold", 32'(stable), 32'd1);
      @(negedge clk);
      txd[s] = 1'b0;
      cap[s] = 1'b0;
      chk("gap_no_start", 32'(ts[s]), 32'd0);
      if (mid && k == 2) chk("overrun_set", 32'(ovr[s]), 32'd1);
      @(negedge clk);
    end
    chk("done_pulse", 32'(done[s]), 32'd1);
    chk("busy_low_at_done", 32'(busy[s]), 32'd0);
    @(negedge clk);
    chk("done_single", 32'(done[s]), 32'd0);
    chk("busy_low_after", 32'(busy[s]), 32'd0);
    if (mid) chk("overrun_sticky", 32'(ovr[s]), 32'd1);
    data = D;
  endtask

  initial begin
    bit quiet;
    rst  = 1'b1;
    data = D;
    mask = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      cap[i] = 1'b0;
      txd[i] = 1'b0;
    end

    vecs[0] = '{sel: 0, mask: 4'b0011, n: 10, bytes: 80'hA5_11_22_33_44_DE_AD_BE_EF_66};
    vecs[1] = '{sel: 1, mask: 4'b1000, n: 5,  bytes: 80'hBE_BA_FE_CA_30_00_00_00_00_00};
    vecs[2] = '{sel: 0, mask: 4'b0000, n: 2,  bytes: 80'hA5_00_00_00_00_00_00_00_00_00};
    vecs[3] = '{sel: 2, mask: 4'b0000, n: 0,  bytes: 80'h0};
    vecs[4] = '{sel: 0, mask: 4'b0100, n: 6,  bytes: 80'hA5_00_00_00_00_00_00_00_00_00};

    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("reset_tx_start", 32'(ts[i]), 32'd0);
      chk("reset_data_tx", 32'(dtx[i]), 32'd0);
      chk("reset_busy", 32'(busy[i]), 32'd0);
      chk("reset_done", 32'(done[i]), 32'd0);
      chk("reset_overrun", 32'(ovr[i]), 32'd0);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int v = 0; v < 5; v++) begin
      run_frame(vecs[v].sel, vecs[v].mask, vecs[v].n, vecs[v].bytes, 1'b0);
      chk("no_overrun", 32'(ovr[vecs[v].sel]), 32'd0);
      repeat (2) @(negedge clk);
    end

    // Capture plus zeroed data mid-frame: frame unchanged, overrun sticks.
    run_frame(0, 4'b0011, 10, vecs[0].bytes, 1'b1);

    // Spurious tx_done in IDLE.
    @(negedge clk);
    txd[0] = 1'b1;
    @(negedge clk);
    txd[0] = 1'b0;
    chk("spurious_no_start", 32'(ts[0]), 32'd0);
    chk("spurious_no_busy", 32'(busy[0]), 32'd0);
    @(negedge clk);
    chk("spurious_no_start2", 32'(ts[0]), 32'd0);
    chk("spurious_no_done", 32'(done[0]), 32'd0);

    // Reset during the 5th byte's WAIT_DONE.
    @(negedge clk);
    data   = D;
    mask   = 4'b0011;
    cap[0] = 1'b1;
    @(negedge clk);
    cap[0] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      repeat (2) @(negedge clk);
      txd[0] = 1'b1;
      @(negedge clk);
      txd[0] = 1'b0;
      @(negedge clk);
    end
    chk("rst_seq_5th_start", 32'(ts[0]), 32'd1);
    chk("rst_seq_5th_byte", 32'(dtx[0]), 32'h44);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_tx_start", 32'(ts[0]), 32'd0);
    chk("midrst_data_tx", 32'(dtx[0]), 32'd0);
    chk("midrst_busy", 32'(busy[0]), 32'd0);
    chk("midrst_done", 32'(done[0]), 32'd0);
    chk("midrst_overrun", 32'(ovr[0]), 32'd0);
    rst   = 1'b0;
    quiet = 1'b1;
    for (int j = 0; j < 15; j++) begin
      @(negedge clk);
      if (j == 3) txd[0] = 1'b1;
      if (j == 4) txd[0] = 1'b0;
      if (ts[0] !== 1'b0 || busy[0] !== 1'b0 || done[0] !== 1'b0) quiet = 1'b0;
    end
    chk("post_reset_quiet", 32'(quiet), 32'd1);
    run_frame(0, 4'b0011, 10, vecs[0].bytes, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

endmodule
